// File: rtl/iq_lane_packer.sv
// iq_lane_packer: buffers NUM_CH I/Q transfers in a FIFO and serialises them as LANE_W-bit framed beats.
// Defining IQ_LANE_PACKER_TEST_PATTERN_EN adds i_pattern_sel, an internal ramp source that bypasses the FIFO.
module iq_lane_packer #(
  parameter int SAMPLE_W   = 12,
  parameter int LANE_W     = 6,
  parameter int NUM_CH     = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int PREFILL    = 2
) (
  input  logic                        i_fpga_clk,
  input  logic                        i_fpga_rst,
`ifdef IQ_LANE_PACKER_TEST_PATTERN_EN
  input  logic                        i_pattern_sel,
`endif
  input  logic                        i_iq_valid,
  output logic                        o_iq_ready,
  input  logic [NUM_CH*SAMPLE_W-1:0]  i_idata,
  input  logic [NUM_CH*SAMPLE_W-1:0]  i_qdata,
  output logic                        o_tx_valid,
  output logic                        o_tx_frame,
  output logic [LANE_W-1:0]           o_tx_data,
  output logic                        o_underflow,
  output logic [15:0]                 o_underflow_cnt,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

  localparam int SEGS    = SAMPLE_W / LANE_W;
  localparam int BEATS   = 2 * NUM_CH * SEGS;
  localparam int ENTRY_W = 2 * NUM_CH * SAMPLE_W;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LVW     = AW + 1;
  localparam int BW      = $clog2(BEATS);

  localparam logic [LVW-1:0] DEPTH_LVL   = LVW'(FIFO_DEPTH);
  localparam logic [LVW-1:0] PREFILL_LVL = LVW'(PREFILL);
  localparam logic [BW-1:0]  LAST_BEAT   = BW'(BEATS - 1);
  localparam logic [BW-1:0]  HALF_BEATS  = BW'(BEATS / 2);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_PATTERN} state_e;

  state_e              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [ENTRY_W-1:0]  entry_q, entry_d;
  logic [ENTRY_W-1:0]  wr_entry, pat_entry;
  logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVW-1:0]      level_q, level_d;
  logic [SAMPLE_W-1:0] ramp_q, ramp_d;
  logic [15:0]         ucnt_q, ucnt_d;
  logic [LANE_W-1:0]   data_q, data_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic                frame_q, frame_d;
  logic                under_q, under_d;
  logic                wr_en, pop, load_pat, pattern_sel;

`ifdef IQ_LANE_PACKER_TEST_PATTERN_EN
  assign pattern_sel = i_pattern_sel;
`else
  assign pattern_sel = 1'b0;
`endif

  // Entry layout puts sample s (beat order: ch0 I, ch0 Q, ch1 I, ...) at bits [s*SAMPLE_W +: SAMPLE_W].
  always_comb begin
    wr_entry  = '0;
    pat_entry = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      wr_entry[2*ch*SAMPLE_W +: SAMPLE_W]      = i_idata[ch*SAMPLE_W +: SAMPLE_W];
      wr_entry[(2*ch+1)*SAMPLE_W +: SAMPLE_W]  = i_qdata[ch*SAMPLE_W +: SAMPLE_W];
      pat_entry[2*ch*SAMPLE_W +: SAMPLE_W]     = ramp_q;
      pat_entry[(2*ch+1)*SAMPLE_W +: SAMPLE_W] = ~ramp_q;
    end
  end

  function automatic logic [LANE_W-1:0] beat_seg(input logic [ENTRY_W-1:0] e,
                                                 input logic [BW-1:0]      b);
    int smp, seg;
    smp = int'(b) / SEGS;
    seg = int'(b) % SEGS;
    return e[(smp*SEGS + SEGS-1-seg)*LANE_W +: LANE_W];
  endfunction

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    entry_d  = entry_q;
    ramp_d   = ramp_q;
    ucnt_d   = ucnt_q;
    under_d  = 1'b0;
    pop      = 1'b0;
    load_pat = 1'b0;
    wr_en    = i_iq_valid & ready_q;

    if (state_q == S_IDLE || beat_q == LAST_BEAT) begin
      // Sequence boundary: choose what feeds the next sequence.
      beat_d = '0;
      if (pattern_sel) begin
        load_pat = 1'b1;
        state_d  = S_PATTERN;
      end else if (state_q == S_PATTERN) begin
        state_d = S_IDLE;
      end else if (state_q == S_IDLE) begin
        if (level_q >= PREFILL_LVL) begin
          pop     = 1'b1;
          state_d = S_STREAM;
        end
      end else if (level_q != '0) begin
        pop = 1'b1;
      end else begin
        state_d = S_IDLE;
        under_d = 1'b1;
        if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
      end
    end else begin
      beat_d = beat_q + BW'(1);
    end

    if (pop) entry_d = mem_q[rd_ptr_q];
    if (load_pat) begin
      entry_d = pat_entry;
      ramp_d  = ramp_q + SAMPLE_W'(1);
    end

    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    level_d  = level_q + LVW'(wr_en) - LVW'(pop);
    if (state_d == S_PATTERN) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end

    ready_d = (state_d != S_PATTERN) && (level_d != DEPTH_LVL);
    valid_d = (state_d != S_IDLE);
    frame_d = valid_d && (beat_d < HALF_BEATS);
    data_d  = valid_d ? beat_seg(entry_d, beat_d) : '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_fpga_clk) begin
    if (i_fpga_rst) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      entry_q  <= '0;
      ramp_q   <= '0;
      ucnt_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      frame_q  <= 1'b0;
      data_q   <= '0;
      under_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      entry_q  <= entry_d;
      ramp_q   <= ramp_d;
      ucnt_q   <= ucnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      frame_q  <= frame_d;
      data_q   <= data_d;
      under_q  <= under_d;
    end
  end

  // NOTE: the storage array is not reset; level and pointers alone decide which entries are live.
  always_ff @(posedge i_fpga_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign o_iq_ready      = ready_q;
  assign o_tx_valid      = valid_q;
  assign o_tx_frame      = frame_q;
  assign o_tx_data       = data_q;
  assign o_underflow     = under_q;
  assign o_underflow_cnt = ucnt_q;
  assign o_fifo_level    = level_q;

endmodule

// File: tb/tb_iq_lane_packer.sv
// Bench for iq_lane_packer: a 1-channel (PREFILL=2) and a 2-channel (PREFILL=8) instance, each compared
// every cycle with a queue-based reference model, plus directed sequences with literal expected beats.
module tb_iq_lane_packer;

  localparam int SW    = 12;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [3:0][SW-1:0] i;
    logic [3:0][SW-1:0] q;
  } xfer_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0, a_pat = 1'b0, b_pat = 1'b0;
  logic [SW-1:0]   a_idata = '0, a_qdata = '0;
  logic [2*SW-1:0] b_idata = '0, b_qdata = '0;

  logic        a_ready, a_tx_valid, a_tx_frame, a_under;
  logic [5:0]  a_tx_data;
  logic [15:0] a_ucnt;
  logic [3:0]  a_level;
  logic        b_ready, b_tx_valid, b_tx_frame, b_under;
  logic [5:0]  b_tx_data;
  logic [15:0] b_ucnt;
  logic [3:0]  b_level;

  iq_lane_packer #(.SAMPLE_W(12), .LANE_W(6), .NUM_CH(1), .FIFO_DEPTH(8), .PREFILL(2)) u_dut_a (
    .i_fpga_clk(clk), .i_fpga_rst(rst),
`ifdef IQ_LANE_PACKER_TEST_PATTERN_EN
    .i_pattern_sel(a_pat),
`endif
    .i_iq_valid(a_valid), .o_iq_ready(a_ready), .i_idata(a_idata), .i_qdata(a_qdata),
    .o_tx_valid(a_tx_valid), .o_tx_frame(a_tx_frame), .o_tx_data(a_tx_data),
    .o_underflow(a_under), .o_underflow_cnt(a_ucnt), .o_fifo_level(a_level)
  );

  iq_lane_packer #(.SAMPLE_W(12), .LANE_W(6), .NUM_CH(2), .FIFO_DEPTH(8), .PREFILL(8)) u_dut_b (
    .i_fpga_clk(clk), .i_fpga_rst(rst),
`ifdef IQ_LANE_PACKER_TEST_PATTERN_EN
    .i_pattern_sel(b_pat),
`endif
    .i_iq_valid(b_valid), .o_iq_ready(b_ready), .i_idata(b_idata), .i_qdata(b_qdata),
    .o_tx_valid(b_tx_valid), .o_tx_frame(b_tx_frame), .o_tx_data(b_tx_data),
    .o_underflow(b_under), .o_underflow_cnt(b_ucnt), .o_fifo_level(b_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  xfer_t       qa[$], qb[$];
  int          m_mode [2] = '{0, 0};   // 0 idle, 1 streaming FIFO data, 2 streaming ramp
  int          m_beat [2] = '{0, 0};
  int          m_ucnt [2] = '{0, 0};
  logic        m_under[2] = '{1'b0, 1'b0};
  logic        m_ready[2] = '{1'b0, 1'b0};
  logic [SW-1:0] m_ramp[2] = '{12'h000, 12'h000};
  xfer_t       m_cur  [2];

  function automatic int nch_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int pre_of(input int k);
    return (k == 0) ? 2 : 8;
  endfunction

  function automatic int m_size(input int k);
    return (k == 0) ? qa.size() : qb.size();
  endfunction

  task automatic m_clear(input int k);
    if (k == 0) qa.delete(); else qb.delete();
  endtask

  task automatic m_push(input int k, input xfer_t x);
    if (k == 0) qa.push_back(x); else qb.push_back(x);
  endtask

  task automatic m_pop(input int k, output xfer_t x);
    if (k == 0) x = qa.pop_front(); else x = qb.pop_front();
  endtask

  task automatic model_step(input int k, input logic r, input logic vld, input xfer_t x, input logic pat);
    int   beats, sz;
    logic acc;
    beats = 4 * nch_of(k);
    if (r) begin
      m_clear(k);
      m_mode[k] = 0; m_beat[k] = 0; m_ucnt[k] = 0;
      m_under[k] = 1'b0; m_ready[k] = 1'b0; m_ramp[k] = '0; m_cur[k] = '0;
      return;
    end
    acc = vld && m_ready[k];
    sz  = m_size(k);
    m_under[k] = 1'b0;
    if (m_mode[k] == 0 || m_beat[k] == beats - 1) begin
      m_beat[k] = 0;
      if (pat) begin
        for (int c = 0; c < 4; c++) begin
          m_cur[k].i[c] = m_ramp[k];
          m_cur[k].q[c] = ~m_ramp[k];
        end
        m_ramp[k] = m_ramp[k] + 12'd1;
        m_mode[k] = 2;
      end else if (m_mode[k] == 2) begin
        m_mode[k] = 0;
      end else if (m_mode[k] == 0) begin
        if (sz >= pre_of(k)) begin
          m_pop(k, m_cur[k]);
          m_mode[k] = 1;
        end
      end else if (sz > 0) begin
        m_pop(k, m_cur[k]);
      end else begin
        m_mode[k]  = 0;
        m_under[k] = 1'b1;
        if (m_ucnt[k] < 65535) m_ucnt[k]++;
      end
    end else begin
      m_beat[k]++;
    end
    if (acc) m_push(k, x);
    if (m_mode[k] == 2) m_clear(k);
    m_ready[k] = (m_mode[k] != 2) && (m_size(k) != DEPTH);
  endtask

  function automatic logic [5:0] exp_data(input int k);
    int smp, seg;
    logic [SW-1:0] s;
    if (m_mode[k] == 0) return 6'h00;
    smp = m_beat[k] / 2;
    seg = m_beat[k] % 2;
    s   = (smp % 2 == 1) ? m_cur[k].q[smp/2] : m_cur[k].i[smp/2];
    return 6'((s >> (SW - (seg + 1) * 6)) & 12'h03F);
  endfunction

  always @(posedge clk) begin : model_clk
    xfer_t xa, xb;
    xa = '0;
    xa.i[0] = a_idata; xa.q[0] = a_qdata;
    xb = '0;
    xb.i[0] = b_idata[11:0]; xb.i[1] = b_idata[23:12];
    xb.q[0] = b_qdata[11:0]; xb.q[1] = b_qdata[23:12];
    model_step(0, rst, a_valid, xa, a_pat);
    model_step(1, rst, b_valid, xb, b_pat);
  end

  task automatic check_dut(input int k, input string n, input logic v, input logic f,
                           input logic [5:0] d, input logic u, input logic [15:0] c,
                           input logic [3:0] l, input logic r);
    check({n, ".valid"}, 32'(v), 32'(m_mode[k] != 0));
    check({n, ".frame"}, 32'(f), 32'(m_mode[k] != 0 && m_beat[k] < 2 * nch_of(k)));
    check({n, ".data"},  32'(d), 32'(exp_data(k)));
    check({n, ".underflow"}, 32'(u), 32'(m_under[k]));
    check({n, ".uf_cnt"}, 32'(c), 32'(m_ucnt[k]));
    check({n, ".level"}, 32'(l), 32'(m_size(k)));
    check({n, ".ready"}, 32'(r), 32'(m_ready[k]));
  endtask

  always @(negedge clk) begin : cycle_check
    check_dut(0, "A", a_tx_valid, a_tx_frame, a_tx_data, a_under, a_ucnt, a_level, a_ready);
    check_dut(1, "B", b_tx_valid, b_tx_frame, b_tx_data, b_under, b_ucnt, b_level, b_ready);
  end

  // ---------------- beat capture for directed checks ----------------
  logic [6:0] cap_a[$], cap_b[$];
  always @(negedge clk) begin : capture
    if (a_tx_valid) cap_a.push_back({a_tx_frame, a_tx_data});
    if (b_tx_valid) cap_b.push_back({b_tx_frame, b_tx_data});
  end

  task automatic push_a(input logic [11:0] i, input logic [11:0] q);
    logic done;
    done = 1'b0;
    a_valid = 1'b1; a_idata = i; a_qdata = q;
    for (int t = 0; t < 20 && !done; t++) begin
      done = a_ready;
      @(negedge clk);
    end
    a_valid = 1'b0;
    check("push_a.accepted", 32'(done), 32'd1);
  endtask

  task automatic wait_a_valid(input int budget);
    for (int t = 0; t < budget && !a_tx_valid; t++) @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  logic [6:0] basic_exp [8] = '{7'h6A, 7'h7C, 7'h04, 7'h23, 7'h40, 7'h40, 7'h3F, 7'h3F};
  logic [6:0] two_exp   [8] = '{7'h44, 7'h51, 7'h48, 7'h62, 7'h0C, 7'h33, 7'h11, 7'h04};
`ifdef IQ_LANE_PACKER_TEST_PATTERN_EN
  logic [6:0] pat_exp   [8] = '{7'h40, 7'h40, 7'h3F, 7'h3F, 7'h40, 7'h41, 7'h3F, 7'h3E};
`endif

  initial begin : main
    int  nacc;
    logic full_seen;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.a_valid", 32'(a_tx_valid), 32'd0);
    check("rst.a_ready", 32'(a_ready), 32'd0);
    check("rst.a_level", 32'(a_level), 32'd0);
    check("rst.b_data",  32'(b_tx_data), 32'd0);
    rst = 1'b0;

    // Basic ordering, back-to-back sequences, then underflow.
    cap_a.delete();
    push_a(12'hABC, 12'h123);
    push_a(12'h000, 12'hFFF);
    repeat (14) @(negedge clk);
    check("basic.beats", 32'(cap_a.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < cap_a.size()) check($sformatf("basic.beat%0d", i), 32'(cap_a[i]), 32'(basic_exp[i]));
    check("uf.cnt", 32'(a_ucnt), 32'd1);
    check("uf.idle", 32'(a_tx_valid), 32'd0);

    // One transfer is below prefill; a second one restarts.
    push_a(12'h5A5, 12'hA5A);
    repeat (6) @(negedge clk);
    check("uf.no_restart", 32'(a_tx_valid), 32'd0);
    check("uf.level1", 32'(a_level), 32'd1);
    push_a(12'h0F0, 12'hF0F);
    wait_a_valid(6);
    check("uf.restart", 32'(a_tx_valid), 32'd1);
    repeat (20) @(negedge clk);
    check("uf.cnt2", 32'(a_ucnt), 32'd2);

    // Reset asserted while beat 2 is on the output.
    push_a(12'h111, 12'h222);
    push_a(12'h333, 12'h444);
    wait_a_valid(6);
    check("mrst.started", 32'(a_tx_valid), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst.valid", 32'(a_tx_valid), 32'd0);
    check("mrst.data",  32'(a_tx_data), 32'd0);
    check("mrst.frame", 32'(a_tx_frame), 32'd0);
    check("mrst.level", 32'(a_level), 32'd0);
    check("mrst.cnt",   32'(a_ucnt), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("mrst.no_resume", 32'(a_tx_valid), 32'd0);

    // Two channels with PREFILL=8: fill to full, then stream under constant backpressure.
    cap_b.delete();
    nacc = 0;
    full_seen = 1'b0;
    b_valid = 1'b1;
    for (int cyc = 0; cyc < 70; cyc++) begin
      if (nacc == 8 && !full_seen) begin
        check("full.level", 32'(b_level), 32'd8);
        check("full.ready", 32'(b_ready), 32'd0);
        full_seen = 1'b1;
      end
      if (nacc < 8) begin
        b_idata = {12'h333, 12'h111};
        b_qdata = {12'h444, 12'h222};
      end else begin
        b_idata = 24'($urandom);
        b_qdata = 24'($urandom);
      end
      if (b_ready) nacc++;
      @(negedge clk);
    end
    b_valid = 1'b0;
    repeat (100) @(negedge clk);
    check("full.seen", 32'(full_seen), 32'd1);
    check("b.no_loss", 32'(cap_b.size()), 32'(nacc * 8));
    for (int i = 0; i < 16; i++)
      if (i < cap_b.size()) check($sformatf("two.beat%0d", i), 32'(cap_b[i]), 32'(two_exp[i % 8]));
    check("b.uf_cnt", 32'(b_ucnt), 32'd1);

`ifdef IQ_LANE_PACKER_TEST_PATTERN_EN
    // Ramp source: R=0,1,2,... with Q=~R, FIFO held empty, no underflow.
    cap_a.delete();
    a_pat = 1'b1;
    a_valid = 1'b1;
    repeat (14) @(negedge clk);
    check("pat.ready", 32'(a_ready), 32'd0);
    check("pat.level", 32'(a_level), 32'd0);
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++)
      if (i < cap_a.size()) check($sformatf("pat.beat%0d", i), 32'(cap_a[i]), 32'(pat_exp[i]));
    a_pat = 1'b0;
    repeat (8) @(negedge clk);
    check("pat.stopped", 32'(a_tx_valid), 32'd0);
    check("pat.no_uf", 32'(a_ucnt), 32'd0);
`endif

    // Randomised traffic with varying input rates and occasional resets.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int rate;
      rate = 15 + 25 * ((cyc / 250) % 3);
      a_valid = ($urandom_range(0, 99) < rate);
      b_valid = ($urandom_range(0, 99) < rate / 2);
      a_idata = 12'($urandom); a_qdata = 12'($urandom);
      b_idata = 24'($urandom); b_qdata = 24'($urandom);
      rst = ($urandom_range(0, 399) == 0);
`ifdef IQ_LANE_PACKER_TEST_PATTERN_EN
      a_pat = ((cyc % 300) > 250);
      b_pat = ((cyc % 400) > 360);
`endif
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0; rst = 1'b0; a_pat = 1'b0; b_pat = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
